kronos_mem_arbiter: RTL and testbench
=====================================

KRONOS_MEM_ARBITER -- requirements
Module: kronos_mem_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2, number of requestor ports, legal range 1..8.
REQ-002 Parameter ARB_MODE, default 0: 0 = fixed priority (port 0 highest), 1 = round-robin.
REQ-003 Parameter MEM_LATENCY, default 1, read latency of the attached single-port RAM in cycles, legal range 1..4.
REQ-004 Parameter AW, default 32, address width.
REQ-005 Parameter DW, default 32, data width, multiple of 8; MW = DW/8.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous reset, active-high.
REQ-008 req  input  N_PORTS  per-port access request.
REQ-009 addr  input  N_PORTS*AW  per-port address; port i occupies bits [i*AW +: AW].
REQ-010 wr_en  input  N_PORTS  per-port write enable, qualified by req.
REQ-011 wr_data  input  N_PORTS*DW  per-port write data.
REQ-012 mask  input  N_PORTS*MW  per-port byte-write mask.
REQ-013 gnt  output  N_PORTS  one-hot grant; request accepted this cycle.
REQ-014 ack  output  N_PORTS  one-hot completion strobe.
REQ-015 rd_data  output  DW  shared read data, valid with ack.
REQ-016 mem_en, mem_wr_en  output  1 each  RAM enable, RAM write enable.
REQ-017 mem_addr  output  AW; mem_wr_data  output  DW; mem_mask  output  MW.
REQ-018 mem_rd_data  input  DW  RAM read data, valid MEM_LATENCY cycles after mem_en.

Function
REQ-019 Grant SHALL be combinational: in any cycle with at least one req bit set and rst low, exactly one gnt bit SHALL be high; with no req, gnt SHALL be 0.
REQ-020 ARB_MODE=0: gnt SHALL go to the lowest-index asserted req.
REQ-021 ARB_MODE=1: search SHALL start at (last+1) mod N_PORTS, where last is the index of the most recent grant; last updates only on cycles with a grant.
REQ-022 mem_en SHALL equal |gnt; mem_wr_en SHALL equal the granted port's wr_en; mem_addr, mem_wr_data, mem_mask SHALL mux from the granted port; when idle, mem_addr, mem_wr_data and mem_mask SHALL be 0.
REQ-023 The arbiter SHALL accept one access per cycle with no bubbles between back-to-back grants.
REQ-024 A requestor that holds req after gnt SHALL be treated as issuing a new access.
REQ-025 The granted port index and a valid bit SHALL enter a MEM_LATENCY-deep shift pipeline.
REQ-026 ack[i] SHALL pulse for one cycle exactly MEM_LATENCY cycles after the gnt[i] cycle, for reads and writes alike.
REQ-027 rd_data SHALL equal mem_rd_data unregistered; its value on write acks is don't-care.
REQ-028 Acks SHALL return in grant order; up to MEM_LATENCY accesses may be in flight.
REQ-029 N_PORTS=1 SHALL degenerate to a pass-through with gnt = req.
REQ-030 In round-robin mode, wrap-around SHALL be from port N_PORTS-1 to port 0.

Reset
REQ-031 While rst is high, gnt, ack, mem_en and mem_wr_en SHALL be 0, and the pipeline valid bits SHALL be 0.
REQ-032 While rst is high, the round-robin last pointer SHALL be N_PORTS-1, so port 0 wins the first contention.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight accesses; no ack for them SHALL appear after rst deasserts.
REQ-034 The first grant SHALL be possible in the first cycle with rst low.

Verification
REQ-035 ARB_MODE=0, N=2, LAT=1; req=2'b11 for 3 cycles -> gnt=01 each cycle; ack[0] in cycles 2..4; port 1 never granted.
REQ-036 ARB_MODE=1, N=3; req=3'b111 held 6 cycles -> gnt sequence 001,010,100,001,010,100.
REQ-037 LAT=2; port 0 writes 0xDEADBEEF to 0x100 with mask 4'hF, then reads 0x100 -> read ack 2 cycles after its grant, rd_data=0xDEADBEEF.
REQ-038 Mask test: write 0xAABBCCDD with mask 4'b0101 over 0x0 -> read returns 0x00BB00DD.
REQ-039 LAT=3; grant port 1, then assert rst 1 cycle later for 2 cycles -> ack stays 0 through 5 cycles after release.
REQ-040 ARB_MODE=1, N=4; req only on port 3, then all ports -> next grant to port 0 (wrap).

Source files
------------

// File: rtl/kronos_mem_arbiter.sv
// kronos_mem_arbiter
//   Shares one single-port RAM between N_PORTS requestors. Grant is combinational:
//   the winning port's command is muxed straight onto the RAM interface in the same
//   cycle. The granted index then travels down a MEM_LATENCY-deep pipeline so the
//   completion strobe (ack) lines up with the RAM's read data.
//
// Parameters
//   N_PORTS     number of requestors (1..8)
//   ARB_MODE    0 = fixed priority (port 0 highest), 1 = round-robin
//   MEM_LATENCY RAM read latency in cycles (1..4)
//   AW, DW      address / data width; DW is a multiple of 8, mask width is DW/8
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req, addr, wr_en, wr_data,    per-port request bundles, port i in slice i
//   mask
//   gnt                           one-hot, access accepted this cycle
//   ack                           one-hot, access completes this cycle
//   rd_data                       shared read data, valid with a read ack
//   mem_en, mem_wr_en, mem_addr,  RAM command, driven from the granted port
//   mem_wr_data, mem_mask
//   mem_rd_data                   RAM read data, MEM_LATENCY cycles after mem_en

module kronos_mem_arbiter #(
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned ARB_MODE    = 0,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS*AW-1:0]       addr,
  input  logic [N_PORTS-1:0]          wr_en,
  input  logic [N_PORTS*DW-1:0]       wr_data,
  input  logic [N_PORTS*(DW/8)-1:0]   mask,
  output logic [N_PORTS-1:0]          gnt,
  output logic [N_PORTS-1:0]          ack,
  output logic [DW-1:0]               rd_data,
  output logic                        mem_en,
  output logic                        mem_wr_en,
  output logic [AW-1:0]               mem_addr,
  output logic [DW-1:0]               mem_wr_data,
  output logic [DW/8-1:0]             mem_mask,
  input  logic [DW-1:0]               mem_rd_data
);

  localparam int unsigned MW = DW / 8;
  localparam int unsigned IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  // Elaboration-time parameter sanity checks
  if (N_PORTS < 1 || N_PORTS > 8) begin : g_bad_n_ports
    $error("kronos_mem_arbiter: N_PORTS must be 1..8");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("kronos_mem_arbiter: MEM_LATENCY must be 1..4");
  end
  if (ARB_MODE > 1) begin : g_bad_mode
    $error("kronos_mem_arbiter: ARB_MODE must be 0 or 1");
  end
  if (DW == 0 || (DW % 8) != 0) begin : g_bad_dw
    $error("kronos_mem_arbiter: DW must be a non-zero multiple of 8");
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [IW-1:0] last_q;   // index of the most recent grant (round-robin pointer)
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;

  always_comb begin
    int cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (ARB_MODE == 0 || N_PORTS == 1) begin
      // Walk downwards so the lowest asserted index is the one left standing.
      for (int i = N_PORTS - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'(i);
        end
      end
    end else begin
      // Candidates in priority order are last+1, last+2, ... (mod N_PORTS);
      // walk that order backwards so the highest-priority hit wins.
      for (int k = N_PORTS - 1; k >= 0; k--) begin
        cand = (int'(last_q) + k + 1) % N_PORTS;
        if (req[IW'(cand)]) begin
          gnt_any = 1'b1;
          gnt_idx = IW'(cand);
        end
      end
    end
    // Nothing is accepted while reset is held.
    if (rst) begin
      gnt_any = 1'b0;
      gnt_idx = '0;
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      gnt[i] = gnt_any && (gnt_idx == IW'(i));
    end
  end

  // Pointer resets to the last port so port 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IW'(N_PORTS - 1);
    end else if (gnt_any) begin
      last_q <= gnt_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM command mux (all zero when idle)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en      = gnt_any;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_mask    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt_any && (gnt_idx == IW'(i))) begin
        mem_wr_en   = wr_en[i];
        mem_addr    = addr[i*AW +: AW];
        mem_wr_data = wr_data[i*DW +: DW];
        mem_mask    = mask[i*MW +: MW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion pipeline: stage s holds the access granted s+1 cycles ago, so the
  // last stage is aligned with mem_rd_data for that access.
  // ---------------------------------------------------------------------------
  logic [MEM_LATENCY-1:0] vld_q;
  logic [IW-1:0]          idx_q [MEM_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < MEM_LATENCY; s++) begin
        idx_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= gnt_any;
      idx_q[0] <= gnt_idx;
      for (int s = 1; s < MEM_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      ack[i] = !rst && vld_q[MEM_LATENCY-1] && (idx_q[MEM_LATENCY-1] == IW'(i));
    end
  end

  // Read data is passed through unregistered; meaningless on write acks.
  assign rd_data = mem_rd_data;

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Bench for kronos_mem_arbiter. Three instances:
//   A: fixed priority, 2 ports, latency 2, with a behavioural byte-masked RAM
//   B: round-robin, 4 ports, latency 3 (reset flush, rotation, wrap-around)
//   C: single port, latency 1 (pass-through)
// Stimulus pushes expected acks into per-instance queues; monitors pop on ack.

module tb_kronos_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          port;
    int          due;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic rst   = 1'b1;
  logic b_rst = 1'b1;

  // ---------------- instance A ----------------
  logic [1:0]  a_req = '0, a_wr_en = '0, a_gnt, a_ack;
  logic [63:0] a_addr = '0, a_wr_data = '0;
  logic [7:0]  a_mask = '0;
  logic [31:0] a_rd_data, a_mem_addr, a_mem_wr_data, a_mem_rd_data;
  logic        a_mem_en, a_mem_wr_en;
  logic [3:0]  a_mem_mask;

  kronos_mem_arbiter #(.N_PORTS(2), .ARB_MODE(0), .MEM_LATENCY(2), .AW(32), .DW(32)) u_a (
    .clk(clk), .rst(rst), .req(a_req), .addr(a_addr), .wr_en(a_wr_en),
    .wr_data(a_wr_data), .mask(a_mask), .gnt(a_gnt), .ack(a_ack), .rd_data(a_rd_data),
    .mem_en(a_mem_en), .mem_wr_en(a_mem_wr_en), .mem_addr(a_mem_addr),
    .mem_wr_data(a_mem_wr_data), .mem_mask(a_mem_mask), .mem_rd_data(a_mem_rd_data)
  );

  // Behavioural RAM, 2-cycle read latency, byte-masked writes
  logic [31:0] ram [256];
  logic [31:0] rdpipe [2];
  initial for (int i = 0; i < 256; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (a_mem_mask[b]) ram[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wr_data[8*b +: 8];
        end
      end
      rdpipe[0] <= ram[a_mem_addr[9:2]];
    end
    rdpipe[1] <= rdpipe[0];
  end
  assign a_mem_rd_data = rdpipe[1];

  // ---------------- instance B ----------------
  logic [3:0]   b_req = '0, b_gnt, b_ack;
  logic [127:0] b_addr = '0, b_wr_data = '0;
  logic [15:0]  b_mask = '0;
  logic [31:0]  b_rd_data, b_mem_addr, b_mem_wr_data;
  logic         b_mem_en, b_mem_wr_en;
  logic [3:0]   b_mem_mask;

  kronos_mem_arbiter #(.N_PORTS(4), .ARB_MODE(1), .MEM_LATENCY(3), .AW(32), .DW(32)) u_b (
    .clk(clk), .rst(b_rst), .req(b_req), .addr(b_addr), .wr_en(4'b0000),
    .wr_data(b_wr_data), .mask(b_mask), .gnt(b_gnt), .ack(b_ack), .rd_data(b_rd_data),
    .mem_en(b_mem_en), .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr),
    .mem_wr_data(b_mem_wr_data), .mem_mask(b_mem_mask), .mem_rd_data(32'h0)
  );

  // ---------------- instance C ----------------
  logic        c_req = 1'b0, c_gnt, c_ack, c_mem_en, c_mem_wr_en;
  logic [31:0] c_addr = 32'h44, c_rd_data, c_mem_addr, c_mem_wr_data;
  logic [3:0]  c_mem_mask;

  kronos_mem_arbiter #(.N_PORTS(1), .ARB_MODE(0), .MEM_LATENCY(1), .AW(32), .DW(32)) u_c (
    .clk(clk), .rst(rst), .req(c_req), .addr(c_addr), .wr_en(1'b0),
    .wr_data(32'h0), .mask(4'h0), .gnt(c_gnt), .ack(c_ack), .rd_data(c_rd_data),
    .mem_en(c_mem_en), .mem_wr_en(c_mem_wr_en), .mem_addr(c_mem_addr),
    .mem_wr_data(c_mem_wr_data), .mem_mask(c_mem_mask), .mem_rd_data(32'h0)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // One cycle on A: drive, check grant/command at negedge, queue expected ack.
  task automatic step_a(input logic [1:0] r, input logic [1:0] we, input logic [31:0] ad0,
                        input logic [31:0] ad1, input logic [31:0] wd, input logic [3:0] mk,
                        input logic [1:0] exp_g, input bit rchk, input logic [31:0] exp_rd);
    logic [31:0] exp_addr;
    logic        exp_we;
    a_req = r; a_wr_en = we; a_addr = {ad1, ad0}; a_wr_data = {wd, wd}; a_mask = {mk, mk};
    exp_addr = exp_g[0] ? ad0 : (exp_g[1] ? ad1 : 32'h0);
    exp_we   = exp_g[0] ? we[0] : (exp_g[1] ? we[1] : 1'b0);
    @(negedge clk);
    chk("a_gnt", 32'(a_gnt), 32'(exp_g));
    chk("a_mem_en", 32'(a_mem_en), 32'(exp_g != 2'b00));
    chk("a_mem_addr", a_mem_addr, exp_addr);
    chk("a_mem_wr_en", 32'(a_mem_wr_en), 32'(exp_we));
    if (exp_g != 2'b00) qa.push_back('{port: oh2i({2'b00, exp_g}), due: cyc + 2,
                                       chk: rchk, data: exp_rd});
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic [3:0] r, input logic [3:0] exp_g, input bit push);
    b_req = r;
    @(negedge clk);
    chk("b_gnt", 32'(b_gnt), 32'(exp_g));
    if (push && exp_g != 4'b0000) qa_b_push(oh2i(exp_g));
    @(posedge clk); #1;
  endtask

  task automatic qa_b_push(input int p);
    qb.push_back('{port: p, due: cyc + 3, chk: 1'b0, data: 32'h0});
  endtask

  // ---------------- monitors ----------------
  exp_t ea, eb;
  always @(negedge clk) begin
    if (a_ack != 2'b00) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL a_ack_unexpected got=%b exp=none (cycle %0d)", a_ack, cyc);
      end else begin
        ea = qa.pop_front();
        if (a_ack !== (2'b01 << ea.port) || cyc != ea.due ||
            (ea.chk && a_rd_data !== ea.data)) begin
          failures++;
          $display("FAIL a_ack got=%b cyc=%0d rd=%h exp_port=%0d due=%0d rd=%h",
                   a_ack, cyc, a_rd_data, ea.port, ea.due, ea.data);
        end
      end
    end
    if (b_ack != 4'b0000) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL b_ack_unexpected got=%b exp=none (cycle %0d)", b_ack, cyc);
      end else begin
        eb = qb.pop_front();
        if (b_ack !== (4'b0001 << eb.port) || cyc != eb.due) begin
          failures++;
          $display("FAIL b_ack got=%b cyc=%0d exp_port=%0d due=%0d",
                   b_ack, cyc, eb.port, eb.due);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] cv;
    logic       prev;

    // Reset: requests asserted but nothing may be granted or acked.
    a_req = 2'b11; b_req = 4'b1111; c_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_gnt", 32'(a_gnt), 32'h0);
    chk("rst_a_mem_en", 32'(a_mem_en), 32'h0);
    chk("rst_a_ack", 32'(a_ack), 32'h0);
    chk("rst_b_gnt", 32'(b_gnt), 32'h0);
    chk("rst_c_gnt", 32'(c_gnt), 32'h0);
    a_req = '0; b_req = '0; c_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; b_rst = 1'b0;

    // A: fixed priority, port 1 starved while port 0 holds req
    step_a(2'b11, 2'b00, 32'h200, 32'h300, 32'h0, 4'h0, 2'b01, 1'b1, 32'h0);
    step_a(2'b11, 2'b00, 32'h200, 32'h300, 32'h0, 4'h0, 2'b01, 1'b1, 32'h0);
    step_a(2'b11, 2'b00, 32'h200, 32'h300, 32'h0, 4'h0, 2'b01, 1'b1, 32'h0);
    step_a(2'b10, 2'b00, 32'h200, 32'h300, 32'h0, 4'h0, 2'b10, 1'b1, 32'h0);
    // Full write then read-back
    step_a(2'b01, 2'b01, 32'h100, 32'h0, 32'hDEADBEEF, 4'hF, 2'b01, 1'b0, 32'h0);
    step_a(2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 4'h0, 2'b01, 1'b1, 32'hDEADBEEF);
    // Masked write from port 1 over 0x0, read back from both ports
    step_a(2'b10, 2'b10, 32'h0, 32'h0, 32'hAABBCCDD, 4'b0101, 2'b10, 1'b0, 32'h0);
    step_a(2'b11, 2'b00, 32'h0, 32'h100, 32'h0, 4'h0, 2'b01, 1'b1, 32'h00BB00DD);
    step_a(2'b10, 2'b00, 32'h0, 32'h100, 32'h0, 4'h0, 2'b10, 1'b1, 32'hDEADBEEF);
    repeat (3) step_a(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 4'h0, 2'b00, 1'b0, 32'h0);

    // B: rotation over ports 0..2, then wrap from 3 to 0
    repeat (2) begin
      step_b(4'b0111, 4'b0001, 1'b1);
      step_b(4'b0111, 4'b0010, 1'b1);
      step_b(4'b0111, 4'b0100, 1'b1);
    end
    step_b(4'b1000, 4'b1000, 1'b1);
    step_b(4'b1111, 4'b0001, 1'b1);
    step_b(4'b0000, 4'b0000, 1'b1);  // idle cycle must not move the pointer
    step_b(4'b1111, 4'b0010, 1'b1);
    repeat (3) step_b(4'b0000, 4'b0000, 1'b1);

    // B: grant port 1, reset one cycle later for two cycles; that access is dropped
    step_b(4'b0010, 4'b0010, 1'b0);
    b_rst = 1'b1; b_req = 4'b1111;
    repeat (2) begin
      @(negedge clk);
      chk("b_rst_gnt", 32'(b_gnt), 32'h0);
      chk("b_rst_ack", 32'(b_ack), 32'h0);
      chk("b_rst_mem_en", 32'(b_mem_en), 32'h0);
      @(posedge clk); #1;
    end
    b_rst = 1'b0;
    repeat (5) step_b(4'b0000, 4'b0000, 1'b1);
    step_b(4'b1111, 4'b0001, 1'b1);  // pointer back at port 3 -> port 0 wins
    repeat (4) step_b(4'b0000, 4'b0000, 1'b1);

    // C: single port is a pass-through, ack one cycle after grant
    cv = 4'b1101;
    prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_req = cv[i];
      @(negedge clk);
      chk("c_gnt", 32'(c_gnt), 32'(cv[i]));
      chk("c_ack", 32'(c_ack), 32'(prev));
      chk("c_mem_addr", c_mem_addr, cv[i] ? 32'h44 : 32'h0);
      prev = cv[i];
      @(posedge clk); #1;
    end
    c_req = 1'b0;
    @(negedge clk);
    chk("c_ack_last", 32'(c_ack), 32'(prev));

    repeat (4) @(posedge clk);
    chk("a_queue_drained", 32'(qa.size()), 32'h0);
    chk("b_queue_drained", 32'(qb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
